// File: rtl/pulse_to_valid_gen_if.sv
// Request-side handshake bundle between event logic, pulse_to_valid_gen and the AXI sink.
// The master modport belongs to the generator, which drives VALID and the status outputs.
interface pulse_to_valid_gen_if #(
    parameter int CNT_W = 4
);
    logic             Req_Pulse;
    logic             READY;
    logic             Clear_Ovf;
    logic             VALID;
    logic [CNT_W-1:0] Pending;
    logic             Overflow;
    logic             Busy;

    modport master (
        input  Req_Pulse,
        input  READY,
        input  Clear_Ovf,
        output VALID,
        output Pending,
        output Overflow,
        output Busy
    );

    modport slave (
        output Req_Pulse,
        output READY,
        output Clear_Ovf,
        input  VALID,
        input  Pending,
        input  Overflow,
        input  Busy
    );
endinterface

// File: rtl/pulse_to_valid_gen.sv
// Turns single-cycle request pulses into a held AXI VALID level. Pulses that arrive during a
// handshake are queued in a saturating counter, and an optional idle gap separates transfers.
module pulse_to_valid_gen #(
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    pulse_to_valid_gen_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAPW   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [7:0]       GAP_V    = 8'(GAP);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pend, pend_nxt;
    logic [7:0]       gap_cnt, gap_nxt;
    logic             ovf, ovf_nxt;
    logic             valid_q;
    logic             hs;
    logic             drop;

    assign hs = valid_q & bus.READY;

    // Pending moves by the net of one new request and one completed handshake per cycle.
    always_comb begin
        pend_nxt = pend;
        drop     = 1'b0;
        if (bus.Req_Pulse && !hs) begin
            if (pend == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pend_nxt = pend + 1'b1;
            end
        end else if (!bus.Req_Pulse && hs) begin
            pend_nxt = pend - 1'b1;
        end

        ovf_nxt = ovf;
        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (bus.Clear_Ovf) begin
            ovf_nxt = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        case (state)
            IDLE: begin
                if (pend != '0 || bus.Req_Pulse) begin
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                if (hs) begin
                    if (GAP == 0) begin
                        state_nxt = (pend_nxt != '0) ? ASSERT : IDLE;
                    end else begin
                        state_nxt = GAPW;
                        gap_nxt   = GAP_V;
                    end
                end
            end
            GAPW: begin
                gap_nxt = gap_cnt - 8'd1;
                // Leaving on the count of 1 keeps VALID low for exactly GAP cycles.
                if (gap_cnt <= 8'd1) begin
                    gap_nxt   = 8'd0;
                    state_nxt = (pend_nxt != '0) ? ASSERT : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gap_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            pend    <= '0;
            gap_cnt <= 8'd0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            gap_cnt <= gap_nxt;
            ovf     <= ovf_nxt;
            valid_q <= (state_nxt == ASSERT);
        end
    end

    assign bus.VALID    = valid_q;
    assign bus.Pending  = pend;
    assign bus.Overflow = ovf;
    assign bus.Busy     = (state != IDLE) || (pend != '0);
endmodule

// File: tb/tb_pulse_to_valid_gen.sv
// Bench for pulse_to_valid_gen: three instances (no gap, GAP=2, 2-bit counter) checked by
// directed scenarios and random traffic against a queue-count/low-time reference model.
module tb_pulse_to_valid_gen;
    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;

    always #5 ACLK = ~ACLK;

    pulse_to_valid_gen_if #(.CNT_W(4)) if0 ();
    pulse_to_valid_gen_if #(.CNT_W(4)) if2 ();
    pulse_to_valid_gen_if #(.CNT_W(2)) ifs ();

    pulse_to_valid_gen #(.CNT_W(4), .GAP(0)) dut0 (.ACLK(ACLK), .ARESETN(ARESETN), .bus(if0.master));
    pulse_to_valid_gen #(.CNT_W(4), .GAP(2)) dut2 (.ACLK(ACLK), .ARESETN(ARESETN), .bus(if2.master));
    pulse_to_valid_gen #(.CNT_W(2), .GAP(0)) duts (.ACLK(ACLK), .ARESETN(ARESETN), .bus(ifs.master));

    logic       req [3];
    logic       rdy [3];
    logic       clr [3];
    logic       vld_o [3];
    logic [3:0] pend_o [3];
    logic       ovf_o [3];
    logic       busy_o [3];

    assign if0.Req_Pulse = req[0];
    assign if0.READY     = rdy[0];
    assign if0.Clear_Ovf = clr[0];
    assign if2.Req_Pulse = req[1];
    assign if2.READY     = rdy[1];
    assign if2.Clear_Ovf = clr[1];
    assign ifs.Req_Pulse = req[2];
    assign ifs.READY     = rdy[2];
    assign ifs.Clear_Ovf = clr[2];

    assign vld_o[0]  = if0.VALID;
    assign vld_o[1]  = if2.VALID;
    assign vld_o[2]  = ifs.VALID;
    assign pend_o[0] = if0.Pending;
    assign pend_o[1] = if2.Pending;
    assign pend_o[2] = {2'b00, ifs.Pending};
    assign ovf_o[0]  = if0.Overflow;
    assign ovf_o[1]  = if2.Overflow;
    assign ovf_o[2]  = ifs.Overflow;
    assign busy_o[0] = if0.Busy;
    assign busy_o[1] = if2.Busy;
    assign busy_o[2] = ifs.Busy;

    // Reference model: outstanding request count plus remaining forced-low cycles.
    int m_gap [3] = '{0, 2, 0};
    int m_max [3] = '{15, 15, 3};
    int m_pend [3];
    int m_low [3];
    bit m_vld [3];
    bit m_ovf [3];

    int total = 0;
    int bad = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 0;
            m_low[k]  = 0;
            m_vld[k]  = 1'b0;
            m_ovf[k]  = 1'b0;
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0;
            rdy[k] = 1'b0;
            clr[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        bit hs;
        bit drop;
        int np;
        hs   = m_vld[k] && (rdy[k] === 1'b1);
        drop = (req[k] === 1'b1) && !hs && (m_pend[k] == m_max[k]);
        np   = m_pend[k] + (((req[k] === 1'b1) && !drop) ? 1 : 0) - (hs ? 1 : 0);
        if (drop) m_ovf[k] = 1'b1;
        else if (clr[k] === 1'b1) m_ovf[k] = 1'b0;
        if (m_vld[k] && !hs) begin
            m_vld[k] = 1'b1;
        end else if (hs && m_gap[k] > 0) begin
            m_low[k] = m_gap[k];
            m_vld[k] = 1'b0;
        end else if (m_low[k] > 0) begin
            m_low[k] = m_low[k] - 1;
            m_vld[k] = (m_low[k] == 0) && (np != 0);
        end else begin
            m_vld[k] = (np != 0);
        end
        m_pend[k] = np;
    endtask

    function automatic bit m_busy(input int k);
        return m_vld[k] || (m_low[k] != 0) || (m_pend[k] != 0);
    endfunction

    // Inputs change on the falling edge; outputs are observed on the following falling edge.
    task automatic tick();
        @(posedge ACLK);
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        clear_inputs();
        ARESETN = 1'b0;
        model_reset();
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (vld_o[k] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_valid[%0d] got=%b want=0", k, vld_o[k]);
            end
            total++;
            if (pend_o[k] !== 4'd0) begin
                bad++;
                $display("[TB] FAIL reset_pending[%0d] got=%0d want=0", k, pend_o[k]);
            end
            total++;
            if (ovf_o[k] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_overflow[%0d] got=%b want=0", k, ovf_o[k]);
            end
            total++;
            if (busy_o[k] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_busy[%0d] got=%b want=0", k, busy_o[k]);
            end
        end
    endtask

    task automatic test_single_pulse();
        req[0] = 1'b1;
        rdy[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        total++;
        if (vld_o[0] !== 1'b1 || pend_o[0] !== 4'd1) begin
            bad++;
            $display("[TB] FAIL single_rise got valid=%b pending=%0d want valid=1 pending=1", vld_o[0], pend_o[0]);
        end
        tick();
        total++;
        if (vld_o[0] !== 1'b0 || pend_o[0] !== 4'd0) begin
            bad++;
            $display("[TB] FAIL single_fall got valid=%b pending=%0d want valid=0 pending=0", vld_o[0], pend_o[0]);
        end
        rdy[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int highs;
        rdy[0] = 1'b0;
        req[0] = 1'b1;
        repeat (3) tick();
        req[0] = 1'b0;
        total++;
        if (pend_o[0] !== 4'd3 || vld_o[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_queued got pending=%0d valid=%b want pending=3 valid=1", pend_o[0], vld_o[0]);
        end
        rdy[0] = 1'b1;
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            if (vld_o[0] === 1'b1) highs++;
            if (i < 3 && vld_o[0] !== 1'b1) begin
                total++;
                bad++;
                $display("[TB] FAIL b2b_consecutive cycle=%0d got valid=%b want 1", i, vld_o[0]);
            end
            tick();
        end
        total++;
        if (highs != 3 || pend_o[0] !== 4'd0) begin
            bad++;
            $display("[TB] FAIL b2b_drain got highs=%0d pending=%0d want highs=3 pending=0", highs, pend_o[0]);
        end
        rdy[0] = 1'b0;
    endtask

    task automatic test_gap();
        bit exp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rdy[1] = 1'b0;
        req[1] = 1'b1;
        repeat (2) tick();
        req[1] = 1'b0;
        rdy[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (vld_o[1] !== exp_pat[i]) begin
                bad++;
                $display("[TB] FAIL gap_pattern cycle=%0d got valid=%b want %b", i, vld_o[1], exp_pat[i]);
            end
            tick();
        end
        total++;
        if (pend_o[1] !== 4'd0 || busy_o[1] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL gap_idle got pending=%0d busy=%b want 0 0", pend_o[1], busy_o[1]);
        end
        rdy[1] = 1'b0;
    endtask

    task automatic test_saturate();
        rdy[2] = 1'b0;
        req[2] = 1'b1;
        repeat (5) tick();
        total++;
        if (pend_o[2] !== 4'd3 || ovf_o[2] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sat_level got pending=%0d overflow=%b want 3 1", pend_o[2], ovf_o[2]);
        end
        clr[2] = 1'b1;
        tick();
        total++;
        if (ovf_o[2] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sat_set_priority got overflow=%b want 1", ovf_o[2]);
        end
        req[2] = 1'b0;
        tick();
        clr[2] = 1'b0;
        total++;
        if (ovf_o[2] !== 1'b0 || pend_o[2] !== 4'd3) begin
            bad++;
            $display("[TB] FAIL sat_clear got overflow=%b pending=%0d want 0 3", ovf_o[2], pend_o[2]);
        end
        rdy[2] = 1'b1;
        repeat (4) tick();
        total++;
        if (pend_o[2] !== 4'd0 || vld_o[2] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sat_drain got pending=%0d valid=%b want 0 0", pend_o[2], vld_o[2]);
        end
        rdy[2] = 1'b0;
    endtask

    task automatic test_reset_midflight();
        rdy[0] = 1'b0;
        req[0] = 1'b1;
        repeat (2) tick();
        req[0] = 1'b0;
        total++;
        if (vld_o[0] !== 1'b1 || pend_o[0] !== 4'd2) begin
            bad++;
            $display("[TB] FAIL midrst_setup got valid=%b pending=%0d want 1 2", vld_o[0], pend_o[0]);
        end
        #2;
        ARESETN = 1'b0;
        #1;
        total++;
        if (vld_o[0] !== 1'b0 || pend_o[0] !== 4'd0) begin
            bad++;
            $display("[TB] FAIL midrst_async got valid=%b pending=%0d want 0 0", vld_o[0], pend_o[0]);
        end
        model_reset();
        clear_inputs();
        @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) tick();
        total++;
        if (vld_o[0] !== 1'b0 || pend_o[0] !== 4'd0 || busy_o[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_after got valid=%b pending=%0d busy=%b want 0 0 0", vld_o[0], pend_o[0], busy_o[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                req[k] = ($urandom_range(99) < ((k == 2) ? 60 : 40));
                rdy[k] = ($urandom_range(99) < ((k == 2) ? 30 : 55));
                clr[k] = ($urandom_range(99) < 10);
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (vld_o[k] !== m_vld[k] || pend_o[k] !== 4'(m_pend[k])
                    || ovf_o[k] !== m_ovf[k] || busy_o[k] !== m_busy(k)) begin
                    bad++;
                    $display("[TB] FAIL random[%0d] cyc=%0d got v=%b p=%0d o=%b b=%b want v=%b p=%0d o=%b b=%b",
                             k, c, vld_o[k], pend_o[k], ovf_o[k], busy_o[k],
                             m_vld[k], m_pend[k], m_ovf[k], m_busy(k));
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_gap();
        test_saturate();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
